// File: rtl/output_collector_pkg.sv
// Shared types and helpers for output_collector: entry layout, stride decode, requantization.
// Defining OUTPUT_COLLECTOR_RELU_EN makes requant() clamp negative accumulators to zero before shifting.
package output_collector_pkg;

  localparam int OC_ACC_W = 32;
  localparam int OC_OUT_W = 16;
  // Address fields are sized for the largest supported map; narrower instances zero-extend.
  localparam int OC_X_W   = 10;
  localparam int OC_Y_W   = 10;
  localparam int OC_CH_W  = 6;

  localparam logic [1:0] STRIDE_MODE_1 = 2'd0;
  localparam logic [1:0] STRIDE_MODE_2 = 2'd1;
  localparam logic [1:0] STRIDE_MODE_4 = 2'd2;

  localparam logic signed [OC_ACC_W-1:0] OC_SAT_MAX = OC_ACC_W'((1 << (OC_OUT_W - 1)) - 1);
  localparam logic signed [OC_ACC_W-1:0] OC_SAT_MIN = ~OC_SAT_MAX;

  typedef struct packed {
    logic signed [OC_OUT_W-1:0] data;
    logic [OC_X_W-1:0]          x;
    logic [OC_Y_W-1:0]          y;
    logic [OC_CH_W-1:0]         ch;
  } out_entry_t;

  function automatic logic [1:0] stride_shift(input logic [1:0] mode);
    case (mode)
      STRIDE_MODE_2: return 2'd1;
      STRIDE_MODE_4: return 2'd2;
      default:       return 2'd0;
    endcase
  endfunction

  function automatic logic signed [OC_OUT_W-1:0] requant(input logic signed [OC_ACC_W-1:0] acc,
                                                         input logic [4:0] shift);
    logic signed [OC_ACC_W-1:0] v;
    v = acc;
`ifdef OUTPUT_COLLECTOR_RELU_EN
    if (v < 0) v = '0;
`endif
    v = v >>> shift;
    if (v > OC_SAT_MAX) v = OC_SAT_MAX;
    else if (v < OC_SAT_MIN) v = OC_SAT_MIN;
    return v[OC_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head is read straight from storage, reset clears storage, flush only pointers.
// A push while full is accepted only together with a pop (the freed slot is the one being written).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_dat,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB tells a full FIFO from an empty one.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count   = r_wr - r_rd;
  assign o_dat     = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_dat;
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/output_collector.sv
// Captures and requantizes output pixels, buffers them, drains over valid/ready; 2-cycle in-to-out latency.
// No upstream backpressure: almost_full warns, drops set sticky overflow. ReLU via OUTPUT_COLLECTOR_RELU_EN.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int ACC_WIDTH          = 32,
  parameter int OUT_WIDTH          = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_in,
  input  logic                                    start,
  input  logic [1:0]                              conv_stride_mode,
  input  logic [4:0]                              shift,
  input  logic                                    in_valid,
  input  logic signed [ACC_WIDTH-1:0]             in_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   in_ch,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic signed [OUT_WIDTH-1:0]             out_data,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   out_ch,
  output logic                                    almost_full,
  output logic                                    overflow,
  output logic                                    frame_done
);
  localparam int XW    = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW    = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW    = $clog2(OUTPUT_NB_CHANNELS);
  localparam int FW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS + 1);

  logic [4:0]       r_shift;
  logic [1:0]       r_stride;
  out_entry_t       r_s1;
  logic             r_s1_vld;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_done;

  out_entry_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic [FW-1:0]    w_fill;
  logic             w_pop;
  logic             w_drop;
  logic             w_push;
  logic [1:0]       w_sshift;
  logic [CNT_W-1:0] w_expected;
  logic             w_done_now;

  assign w_pop      = !w_empty && out_ready;
  assign w_drop     = r_s1_vld && w_full && !w_pop;
  assign w_push     = r_s1_vld && !w_drop;
  assign w_sshift   = stride_shift(r_stride);
  assign w_expected = CNT_W'((FEATURE_MAP_WIDTH >> w_sshift) * (FEATURE_MAP_HEIGHT >> w_sshift)
                             * OUTPUT_NB_CHANNELS);
  assign w_done_now = (r_count == w_expected) && !r_s1_vld && w_empty;

  sync_fifo #(
    .WIDTH ($bits(out_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst_in),
    .i_flush (start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (r_s1),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fill)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_shift    <= '0;
      r_stride   <= '0;
      r_s1       <= '0;
      r_s1_vld   <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else if (start) begin
      r_shift    <= shift;
      r_stride   <= conv_stride_mode;
      r_s1_vld   <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1.data <= requant(OC_ACC_W'(in_data), r_shift);
        r_s1.x    <= OC_X_W'(in_x);
        r_s1.y    <= OC_Y_W'(in_y);
        r_s1.ch   <= OC_CH_W'(in_ch);
        // Captures past the frame size still flow through; only the count stops.
        if (r_count < w_expected) r_count <= r_count + CNT_W'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_done_now) r_done <= 1'b1;
    end
  end

  assign out_valid   = !w_empty;
  assign out_data    = OUT_WIDTH'(w_head.data);
  assign out_x       = XW'(w_head.x);
  assign out_y       = YW'(w_head.y);
  assign out_ch      = CW'(w_head.ch);
  assign almost_full = (int'(w_fill) + int'(r_s1_vld)) >= (FIFO_DEPTH - 1);
  assign overflow    = r_overflow;
  assign frame_done  = r_done || w_done_now;

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: directed scenarios plus a randomized run against a queue-level reference model.
// A second, small-geometry instance (4x4x2 map) exercises end-of-frame detection.
module tb_output_collector;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_in, start, in_valid, out_ready;
  logic [1:0]         stride;
  logic [4:0]         shift;
  logic signed [31:0] in_data;
  logic [9:0]         in_x, in_y;
  logic [5:0]         in_ch;
  logic               out_valid, almost_full, overflow, frame_done;
  logic signed [15:0] out_data;
  logic [9:0]         out_x, out_y;
  logic [5:0]         out_ch;

  logic               s_rst, s_start, s_in_valid, s_ready;
  logic [1:0]         s_stride;
  logic [4:0]         s_shift;
  logic signed [31:0] s_in_data;
  logic [1:0]         s_in_x, s_in_y, s_out_x, s_out_y;
  logic [0:0]         s_in_ch, s_out_ch;
  logic               s_out_valid, s_almost_full, s_overflow, s_frame_done;
  logic signed [15:0] s_out_data;

  output_collector #(.ACC_WIDTH(32), .OUT_WIDTH(16), .FIFO_DEPTH(DEPTH), .FEATURE_MAP_WIDTH(1024),
                     .FEATURE_MAP_HEIGHT(1024), .OUTPUT_NB_CHANNELS(64)) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .conv_stride_mode(stride), .shift(shift),
    .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_ch(out_ch), .almost_full(almost_full), .overflow(overflow), .frame_done(frame_done));

  output_collector #(.ACC_WIDTH(32), .OUT_WIDTH(16), .FIFO_DEPTH(DEPTH), .FEATURE_MAP_WIDTH(4),
                     .FEATURE_MAP_HEIGHT(4), .OUTPUT_NB_CHANNELS(2)) dut_s (
    .clk(clk), .rst_in(s_rst), .start(s_start), .conv_stride_mode(s_stride), .shift(s_shift),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_x(s_in_x), .in_y(s_in_y), .in_ch(s_in_ch),
    .out_valid(s_out_valid), .out_ready(s_ready), .out_data(s_out_data), .out_x(s_out_x),
    .out_y(s_out_y), .out_ch(s_out_ch), .almost_full(s_almost_full), .overflow(s_overflow),
    .frame_done(s_frame_done));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] d;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [5:0]  ch;
  } ent_t;

  function automatic logic [15:0] ref_requant(input longint acc, input int sh);
    longint v = acc;
`ifdef OUTPUT_COLLECTOR_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] sh);
    start = 1'b1; shift = sh; stride = 2'd0; in_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; s_rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_almost_full got %b exp 0", almost_full); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    n_vec++; if ({out_data, out_x, out_y, out_ch} !== 42'd0) begin
      n_err++; $display("FAIL rst_head got %h/%h/%h/%h exp 0", out_data, out_x, out_y, out_ch); end
    n_vec++; if (s_out_valid !== 1'b0 || s_frame_done !== 1'b0) begin
      n_err++; $display("FAIL rst_small got v=%b fd=%b exp 0", s_out_valid, s_frame_done); end
    tick();
    rst_in = 1'b0; s_rst = 1'b0;
  endtask

  task automatic test_single_pixel();
    do_start(5'd4);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h0000_0123; in_x = 10'd5; in_y = 10'd7; in_ch = 6'd3;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sp_n0_valid got %b exp 0", out_valid); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sp_n1_valid got %b exp 0", out_valid); end
    tick();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sp_n2_valid got %b exp 1", out_valid); end
    n_vec++; if (out_data !== 16'h0012 || out_x !== 10'd5 || out_y !== 10'd7 || out_ch !== 6'd3) begin
      n_err++; $display("FAIL sp_fields got %h/%0d/%0d/%0d exp 0012/5/7/3", out_data, out_x, out_y, out_ch); end
    tick();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sp_n3_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [15:0] e_pos, e_neg;
    e_pos = ref_requant(longint'(32'sh0001_0000), 0);
    e_neg = ref_requant(-100000, 0);
    do_start(5'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'sh0001_0000; tick();
    in_data = -32'sd100000; tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== e_pos) begin
      n_err++; $display("FAIL sat_pos got v=%b %h exp 1 %h", out_valid, out_data, e_pos); end
    n_vec++; if (out_data !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos_const got %h exp 7fff", out_data); end
    tick();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== e_neg) begin
      n_err++; $display("FAIL sat_neg got v=%b %h exp 1 %h", out_valid, out_data, e_neg); end
  endtask

  task automatic test_overflow();
    do_start(5'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = k + 1; in_x = 10'(k); in_y = 10'd0; in_ch = 6'd0;
      @(negedge clk);
      n_vec++; if (almost_full !== (k >= 3)) begin
        n_err++; $display("FAIL ovf_almost_full_%0d got %b exp %b", k, almost_full, (k >= 3)); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early_%0d got %b exp 0", k, overflow); end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", overflow); end
    tick();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1 || out_data !== 16'(j + 1) || out_x !== 10'(j)) begin
        n_err++; $display("FAIL ovf_pop_%0d got v=%b %h x=%0d exp 1 %h x=%0d", j, out_valid, out_data, out_x, j + 1, j); end
      tick();
    end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_pop_count got extra entry %h", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    int pops = 0;
    do_start(5'd0);
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin in_valid = 1'b1; in_data = k; exp_q.push_back(16'(k)); tick(); end
    in_valid = 1'b0; tick();
    for (int c = 0; c < 26; c++) begin
      in_valid = (c < 8);
      in_data = 10 + c;
      if (c < 8) exp_q.push_back(16'(10 + c));
      out_ready = (c >= 1);
      @(negedge clk);
      if (c == 1) begin
        n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL b2b_full got %b exp 1", almost_full); end
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow_%0d got %b exp 0", c, overflow); end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra got %h exp none", out_data); end
        else begin
          if (out_data !== exp_q[0]) begin n_err++; $display("FAIL b2b_order got %h exp %h", out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        pops++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (pops != 12) begin n_err++; $display("FAIL b2b_pop_count got %0d exp 12", pops); end
  endtask

  task automatic test_start_midstream();
    do_start(5'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin in_valid = 1'b1; in_data = 50 + k; tick(); end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (overflow !== 1'b1 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL stm_pre got ovf=%b v=%b exp 1 1", overflow, out_valid); end
    tick();
    start = 1'b1; in_valid = 1'b1; in_data = 99;
    tick();
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      n_err++; $display("FAIL stm_flush got v=%b ovf=%b af=%b exp 0 0 0", out_valid, overflow, almost_full); end
    tick();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stm_start_wins got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    do_start(5'd4);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin in_valid = 1'b1; in_data = 32'h100 * (k + 1); tick(); end
    in_valid = 1'b0; tick();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rsm_pre got %b exp 1", out_valid); end
    tick();
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h123; in_x = 10'd9; in_y = 10'd1; in_ch = 6'd2;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 16'h0000) begin
      n_err++; $display("FAIL rsm_clear got v=%b ovf=%b d=%h exp 0 0 0000", out_valid, overflow, out_data); end
    tick(); in_valid = 1'b0; tick();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== ref_requant(32'h123, 0)) begin
      n_err++; $display("FAIL rsm_shift_cleared got v=%b %h exp 1 %h", out_valid, out_data, ref_requant(32'h123, 0)); end
    tick();
  endtask

  task automatic test_random(input int cycles, input logic [4:0] sh, input int ready_pct);
    ent_t mq[$];
    ent_t st;
    bit   st_v = 0;
    bit   m_ovf = 0;
    do_start(sh);
    for (int c = 0; c < cycles; c++) begin
      in_valid  = ($urandom_range(0, 99) < 65);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      case ($urandom_range(0, 2))
        0: in_data = $urandom();
        1: in_data = $signed(32'($urandom_range(0, 200000))) - 100000;
        default: in_data = $signed(32'($urandom_range(0, 65535))) - 32768;
      endcase
      in_x = 10'($urandom()); in_y = 10'($urandom()); in_ch = 6'($urandom());
      @(negedge clk);
      n_vec++; if (out_valid !== (mq.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, out_valid, (mq.size() > 0)); end
      if (mq.size() > 0) begin
        n_vec++; if (out_data !== mq[0].d || out_x !== mq[0].x || out_y !== mq[0].y || out_ch !== mq[0].ch) begin
          n_err++; $display("FAIL rnd_head c=%0d got %h/%h/%h/%h exp %h/%h/%h/%h", c, out_data, out_x, out_y,
                            out_ch, mq[0].d, mq[0].x, mq[0].y, mq[0].ch); end
      end
      n_vec++; if (almost_full !== ((mq.size() + int'(st_v)) >= DEPTH - 1)) begin
        n_err++; $display("FAIL rnd_almost_full c=%0d got %b exp occ %0d", c, almost_full, mq.size() + int'(st_v)); end
      n_vec++; if (overflow !== m_ovf || frame_done !== 1'b0) begin
        n_err++; $display("FAIL rnd_flags c=%0d got ovf=%b fd=%b exp %b 0", c, overflow, frame_done, m_ovf); end
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (st_v) begin
        if (mq.size() < DEPTH) mq.push_back(st);
        else m_ovf = 1;
      end
      st_v = in_valid;
      st = '{d: ref_requant(longint'(in_data), int'(sh)), x: in_x, y: in_y, ch: in_ch};
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_frame_done();
    int  fifo_n = 0, sent = 0, cyc = 0, last_pop = -1, first_done = -1;
    bit  stage_v = 0, seen = 0, exp_done;
    s_start = 1'b1; s_stride = 2'd1; tick(); s_start = 1'b0;
    while (cyc < 300 && first_done < 0) begin
      s_in_valid = (sent < 8) && ($urandom_range(0, 2) != 0);
      s_ready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_done = seen || (sent == 8 && !stage_v && fifo_n == 0);
      n_vec++; if (s_frame_done !== exp_done) begin
        n_err++; $display("FAIL fd_level c=%0d got %b exp %b", cyc, s_frame_done, exp_done); end
      n_vec++; if (s_out_valid !== (fifo_n > 0)) begin
        n_err++; $display("FAIL fd_valid c=%0d got %b exp %b", cyc, s_out_valid, (fifo_n > 0)); end
      if (fifo_n > 0 && s_ready) begin last_pop = cyc; fifo_n--; end
      if (s_frame_done && first_done < 0) first_done = cyc;
      if (stage_v && fifo_n < DEPTH) fifo_n++;
      stage_v = s_in_valid;
      if (s_in_valid) sent++;
      seen = exp_done;
      cyc++;
      tick();
    end
    s_in_valid = 1'b0;
    n_vec++; if (first_done < 0 || first_done - last_pop != 1) begin
      n_err++; $display("FAIL fd_rise got done@%0d lastpop@%0d exp one cycle apart", first_done, last_pop); end
    s_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_in_valid = (c < 2);
      @(negedge clk);
      n_vec++; if (s_frame_done !== 1'b1) begin n_err++; $display("FAIL fd_hold_%0d got %b exp 1", c, s_frame_done); end
      tick();
    end
    s_in_valid = 1'b0;
    s_start = 1'b1; tick(); s_start = 1'b0;
    @(negedge clk);
    n_vec++; if (s_frame_done !== 1'b0) begin n_err++; $display("FAIL fd_start_clear got %b exp 0", s_frame_done); end
    tick();
    for (int c = 0; c < 11; c++) begin s_in_valid = (c < 7); tick(); end
    @(negedge clk);
    n_vec++; if (s_frame_done !== 1'b0) begin n_err++; $display("FAIL fd_seven got %b exp 0", s_frame_done); end
    tick();
    s_in_valid = 1'b1; tick(); s_in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    n_vec++; if (s_frame_done !== 1'b1) begin n_err++; $display("FAIL fd_eighth got %b exp 1", s_frame_done); end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stride = 2'd0; shift = 5'd0;
    in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
    s_rst = 1'b1; s_start = 1'b0; s_in_valid = 1'b0; s_ready = 1'b0; s_stride = 2'd0; s_shift = 5'd0;
    s_in_data = 32'sd77; s_in_x = 2'd1; s_in_y = 2'd2; s_in_ch = 1'b1;
    #1;
    test_reset();
    test_single_pixel();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_start_midstream();
    test_reset_midstream();
    test_random(400, 5'($urandom_range(0, 31)), 40);
    test_random(300, 5'd0, 85);
    test_random(200, 5'd31, 20);
    test_frame_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
